// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix row side.
// Column mirroring lives here so every column consumer folds physical columns the same way.
package matrix_pkg;

  localparam int MATRIX_ROWS  = 7;
  localparam int MATRIX_COLS  = 5;
  localparam int MATRIX_UCOLS = (MATRIX_COLS + 1) / 2;

  typedef logic [MATRIX_ROWS-1:0] row_t;
  typedef logic [1:0]             col_idx_t;

  // Physical column k -> stored column; the right half mirrors the left half.
  function automatic col_idx_t mirror_index(input int k, input int cols = MATRIX_COLS);
    if (k < (cols + 1) / 2) return col_idx_t'(k);
    else                    return col_idx_t'(cols - 1 - k);
  endfunction

endpackage

// File: rtl/matrix_row_driver_if.sv
// Column-write channel from the display controller into the row driver shadow buffer.
interface matrix_row_driver_if
  import matrix_pkg::*;
#(
  parameter int ROWS = MATRIX_ROWS
) ();

  logic            wr_valid;
  logic            wr_ready;
  col_idx_t        wr_index;
  logic [ROWS-1:0] wr_data;
  logic            wr_last;

  modport master (output wr_valid, wr_index, wr_data, wr_last, input  wr_ready);
  modport slave  (input  wr_valid, wr_index, wr_data, wr_last, output wr_ready);

endinterface

// File: rtl/onehot_to_index.sv
// Folds a one-hot physical column select into {valid, stored column index}.
module onehot_to_index
  import matrix_pkg::*;
#(
  parameter int COLS = MATRIX_COLS
) (
  input  logic [COLS-1:0] col,
  output logic            o_valid,
  output col_idx_t        o_index
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_valid = $onehot(col);
    o_index = '0;
    for (int k = 0; k < COLS; k++) begin
      if (col[k]) o_index = mirror_index(k, COLS);
    end
  end

endmodule

// File: rtl/matrix_row_driver.sv
// Double-buffered row driver for the mirrored LED matrix; images swap only at frame boundaries.
// Optional blink gating is built when MATRIX_ROW_DRIVER_BLINK_EN is defined.
module matrix_row_driver
  import matrix_pkg::*;
#(
  parameter int ROWS         = MATRIX_ROWS,
  parameter int COLS         = MATRIX_COLS,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [COLS-1:0]     col,
  matrix_row_driver_if.slave  wr,
  output logic                swap_pending,
  output logic [ROWS-1:0]     rows,
  output logic                col_error,
  input  logic                blink
);

  localparam int       U     = (COLS + 1) / 2;
  localparam col_idx_t U_IDX = col_idx_t'(U);

  logic [ROWS-1:0] r_active [U];
  logic [ROWS-1:0] r_shadow [U];
  logic [COLS-1:0] r_col_prev;
  logic            r_swap_pending;
  logic [ROWS-1:0] r_rows;
  logic            r_col_error;

  logic            w_valid;
  col_idx_t        w_index;
  logic            w_boundary;
  logic            w_wr_fire;
  logic            w_swap;
  logic            w_blank;
  logic [ROWS-1:0] w_row;

  onehot_to_index #(.COLS(COLS)) u_col_map (
    .col     (col),
    .o_valid (w_valid),
    .o_index (w_index)
  );

  assign w_boundary = r_col_prev[0] & col[COLS-1];
  assign w_wr_fire  = wr.wr_valid & wr.wr_ready;
  assign w_swap     = w_boundary & r_swap_pending;
  // The swapping cycle already shows the new image, so bypass the active buffer.
  assign w_row      = w_swap ? r_shadow[w_index] : r_active[w_index];

  assign wr.wr_ready  = ~r_swap_pending;
  assign swap_pending = r_swap_pending;
  assign rows         = r_rows;
  assign col_error    = r_col_error;

`ifdef MATRIX_ROW_DRIVER_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] r_frame;
  logic          r_phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frame <= '0;
      r_phase <= 1'b0;
    end else if (w_boundary) begin
      if (r_frame == FW'(BLINK_FRAMES - 1)) begin
        r_frame <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_frame <= r_frame + 1'b1;
      end
    end
  end

  assign w_blank = blink & r_phase;
`else
  logic w_unused;
  assign w_unused = blink | (BLINK_FRAMES < 1);
  assign w_blank  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: both image buffers are reset on purpose; a reset must leave the display blank.
      for (int i = 0; i < U; i++) begin
        r_active[i] <= '0;
        r_shadow[i] <= '0;
      end
      r_col_prev     <= '0;
      r_swap_pending <= 1'b0;
      r_rows         <= '0;
      r_col_error    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_col_prev  <= col;
      r_col_error <= ~w_valid;
      r_rows      <= (w_valid && !w_blank) ? w_row : '0;

      if (w_swap) begin
        for (int i = 0; i < U; i++) r_active[i] <= r_shadow[i];
        r_swap_pending <= 1'b0;
      end else if (w_wr_fire && wr.wr_last) begin
        r_swap_pending <= 1'b1;
      end

      if (w_wr_fire && (wr.wr_index < U_IDX)) r_shadow[wr.wr_index] <= wr.wr_data;
    end
  end

endmodule

// File: tb/tb_matrix_row_driver.sv
// Randomized self-checking bench for matrix_row_driver against a frame-level image model.
// Blink checks are included when MATRIX_ROW_DRIVER_BLINK_EN is defined.
module tb_matrix_row_driver;

  localparam int ROWS = 7;
  localparam int COLS = 5;
  localparam int U    = 3;
  localparam int BF   = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [COLS-1:0] col;
  logic            swap_pending;
  logic [ROWS-1:0] rows;
  logic            col_error;
  logic            blink;

  matrix_row_driver_if #(.ROWS(ROWS)) bus ();

  matrix_row_driver #(.ROWS(ROWS), .COLS(COLS), .BLINK_FRAMES(BF)) dut (
    .clock        (clock),
    .reset        (reset),
    .col          (col),
    .wr           (bus),
    .swap_pending (swap_pending),
    .rows         (rows),
    .col_error    (col_error),
    .blink        (blink)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: displayed image, pending image, and a count of frame boundaries.
  logic [ROWS-1:0] m_active [U];
  logic [ROWS-1:0] m_shadow [U];
  bit              m_pending;
  logic [COLS-1:0] m_prev;
  int              m_bounds;
  int              scan_pos;

  function automatic int stored_of(input int k);
    return (k < U) ? k : COLS - 1 - k;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < U; i++) begin
      m_active[i] = '0;
      m_shadow[i] = '0;
    end
    m_pending = 0;
    m_prev    = '0;
    m_bounds  = 0;
  endtask

  task automatic next_col();
    col      = COLS'(1 << scan_pos);
    scan_pos = (scan_pos == 0) ? COLS - 1 : scan_pos - 1;
  endtask

  task automatic idle_wr();
    bus.wr_valid = 1'b0;
    bus.wr_index = '0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic set_wr(input int idx, input logic [ROWS-1:0] data, input bit last);
    bus.wr_valid = 1'b1;
    bus.wr_index = 2'(idx);
    bus.wr_data  = data;
    bus.wr_last  = last;
  endtask

  // Advances model and DUT by one clock; returns what rows/col_error must show afterwards.
  task automatic step(output logic [ROWS-1:0] er, output bit ee, output bit swapped);
    logic [ROWS-1:0] img [U];
    bit boundary, fire;
    int pos;
    boundary = m_prev[0] && col[COLS-1];
    fire     = bus.wr_valid && !m_pending;
    swapped  = boundary && m_pending;
    for (int i = 0; i < U; i++) img[i] = swapped ? m_shadow[i] : m_active[i];
    ee  = ($countones(col) != 1);
    er  = '0;
    pos = 0;
    if (!ee) begin
      for (int k = 0; k < COLS; k++) if (col[k]) pos = k;
      er = img[stored_of(pos)];
    end
`ifdef MATRIX_ROW_DRIVER_BLINK_EN
    if (blink && ((m_bounds / BF) % 2 == 1)) er = '0;
`endif
    if (boundary) m_bounds++;
    if (swapped) begin
      for (int i = 0; i < U; i++) m_active[i] = m_shadow[i];
      m_pending = 0;
    end
    if (fire) begin
      if (int'(bus.wr_index) < U) m_shadow[int'(bus.wr_index)] = bus.wr_data;
      if (bus.wr_last) m_pending = 1;
    end
    m_prev = col;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [ROWS-1:0] er;
    bit ee, sw;
    reset = 1'b0;
    col   = 5'b10000;
    blink = 1'b0;
    idle_wr();
    model_reset();
    #12;
    n_checks++; if (rows !== '0)        $display("FAIL reset_rows: got %h want 00", rows);     else n_pass++;
    n_checks++; if (col_error !== 1'b0) $display("FAIL reset_col_error: got %b want 0", col_error); else n_pass++;
    n_checks++; if (swap_pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", swap_pending); else n_pass++;
    n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.wr_ready); else n_pass++;
    @(negedge clock);
    reset    = 1'b1;
    scan_pos = COLS - 1;
    repeat (COLS) begin
      next_col();
      step(er, ee, sw);
      n_checks++; if (rows !== er)          $display("FAIL blank_rows: got %h want %h", rows, er); else n_pass++;
      n_checks++; if (col_error !== ee)     $display("FAIL blank_col_error: got %b want %b", col_error, ee); else n_pass++;
      n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL blank_ready: got %b want 1", bus.wr_ready); else n_pass++;
    end
  endtask

  task automatic test_load();
    logic [ROWS-1:0] er;
    logic [ROWS-1:0] frame_exp [COLS];
    bit ee, sw;
    frame_exp = '{7'h41, 7'h22, 7'h1C, 7'h22, 7'h41};
    next_col(); step(er, ee, sw);
    next_col(); step(er, ee, sw);
    for (int i = 0; i < U; i++) begin
      next_col();
      set_wr(i, (i == 0) ? 7'h41 : (i == 1) ? 7'h22 : 7'h1C, i == U - 1);
      step(er, ee, sw);
      n_checks++; if (rows !== er) $display("FAIL load_pre_swap_rows: got %h want %h", rows, er); else n_pass++;
    end
    idle_wr();
    n_checks++; if (swap_pending !== 1'b1) $display("FAIL load_pending_set: got %b want 1", swap_pending); else n_pass++;
    for (int s = 0; s < COLS; s++) begin
      next_col();
      step(er, ee, sw);
      n_checks++; if (rows !== frame_exp[s]) $display("FAIL load_frame_rows[%0d]: got %h want %h", s, rows, frame_exp[s]); else n_pass++;
      n_checks++; if (rows !== er) $display("FAIL load_model_rows[%0d]: got %h want %h", s, rows, er); else n_pass++;
      n_checks++; if (swap_pending !== m_pending) $display("FAIL load_pending[%0d]: got %b want %b", s, swap_pending, m_pending); else n_pass++;
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [ROWS-1:0] er;
    bit ee, sw, swap_seen, after_swap;
    swap_seen  = 0;
    after_swap = 0;
    next_col(); set_wr(0, 7'h7F, 0); step(er, ee, sw);
    next_col(); set_wr(1, 7'h00, 0); step(er, ee, sw);
    next_col(); set_wr(2, 7'h55, 1); step(er, ee, sw);
    set_wr(0, 7'h11, 0);
    for (int s = 0; s < 2 * COLS && !after_swap; s++) begin
      next_col();
      swap_seen = sw;
      step(er, ee, sw);
      if (swap_seen) begin
        after_swap = 1;
        n_checks++; if (swap_pending !== 1'b0) $display("FAIL stall_accept_pending: got %b want 0", swap_pending); else n_pass++;
      end else if (!sw) begin
        n_checks++; if (bus.wr_ready !== 1'b0) $display("FAIL stall_ready_low: got %b want 0", bus.wr_ready); else n_pass++;
      end else begin
        n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL stall_ready_after_swap: got %b want 1", bus.wr_ready); else n_pass++;
      end
      n_checks++; if (rows !== er) $display("FAIL stall_rows: got %h want %h", rows, er); else n_pass++;
    end
    n_checks++; if (!after_swap) $display("FAIL stall_swap_timeout: got no swap want swap"); else n_pass++;
    idle_wr();
    for (int s = 0; s < COLS; s++) begin
      next_col(); step(er, ee, sw);
      n_checks++; if (rows !== er) $display("FAIL stall_image_rows: got %h want %h", rows, er); else n_pass++;
    end
  endtask

  task automatic test_col_error();
    logic [ROWS-1:0] er;
    bit ee, sw;
    col = 5'b00110; step(er, ee, sw);
    n_checks++; if (col_error !== 1'b1) $display("FAIL err_multi_flag: got %b want 1", col_error); else n_pass++;
    n_checks++; if (rows !== er) $display("FAIL err_multi_rows: got %h want %h", rows, er); else n_pass++;
    col = 5'b00000; step(er, ee, sw);
    n_checks++; if (col_error !== 1'b1) $display("FAIL err_zero_flag: got %b want 1", col_error); else n_pass++;
    n_checks++; if (rows !== er) $display("FAIL err_zero_rows: got %h want %h", rows, er); else n_pass++;
    next_col(); step(er, ee, sw);
    n_checks++; if (col_error !== 1'b0) $display("FAIL err_clear_flag: got %b want 0", col_error); else n_pass++;
    n_checks++; if (rows !== er) $display("FAIL err_clear_rows: got %h want %h", rows, er); else n_pass++;
  endtask

  task automatic test_selector_held();
    logic [ROWS-1:0] er;
    bit ee, sw;
    col = 5'b10000;
    set_wr(1, 7'h3C, 1); step(er, ee, sw);
    idle_wr();
    repeat (2 * COLS) begin
      step(er, ee, sw);
      n_checks++; if (swap_pending !== 1'b1) $display("FAIL held_pending: got %b want 1", swap_pending); else n_pass++;
      n_checks++; if (rows !== er) $display("FAIL held_rows: got %h want %h", rows, er); else n_pass++;
    end
    scan_pos = COLS - 2;
    repeat (2 * COLS) begin
      next_col(); step(er, ee, sw);
      n_checks++; if (swap_pending !== m_pending) $display("FAIL held_resume_pending: got %b want %b", swap_pending, m_pending); else n_pass++;
      n_checks++; if (rows !== er) $display("FAIL held_resume_rows: got %h want %h", rows, er); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_load();
    logic [ROWS-1:0] er;
    bit ee, sw;
    next_col(); set_wr(0, 7'h5A, 0); step(er, ee, sw);
    next_col(); set_wr(1, 7'h2D, 0); step(er, ee, sw);
    idle_wr();
    reset = 1'b0;
    model_reset();
    #2;
    n_checks++; if (rows !== '0)         $display("FAIL midrst_rows: got %h want 00", rows); else n_pass++;
    n_checks++; if (swap_pending !== 1'b0) $display("FAIL midrst_pending: got %b want 0", swap_pending); else n_pass++;
    @(negedge clock);
    reset    = 1'b1;
    scan_pos = COLS - 1;
    repeat (COLS) begin
      next_col(); step(er, ee, sw);
      n_checks++; if (rows !== er) $display("FAIL midrst_frame_rows: got %h want %h", rows, er); else n_pass++;
      n_checks++; if (swap_pending !== 1'b0) $display("FAIL midrst_frame_pending: got %b want 0", swap_pending); else n_pass++;
    end
    next_col(); set_wr(2, 7'h7E, 1); step(er, ee, sw);
    idle_wr();
    repeat (2 * COLS) begin
      next_col(); step(er, ee, sw);
      n_checks++; if (rows !== er) $display("FAIL midrst_partial_rows: got %h want %h", rows, er); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [ROWS-1:0] er;
    bit ee, sw;
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 9) == 0) col = COLS'($urandom);
      else next_col();
      if ($urandom_range(0, 1) == 1)
        set_wr(int'($urandom_range(0, 3)), ROWS'($urandom), $urandom_range(0, 3) == 0);
      else idle_wr();
      step(er, ee, sw);
      n_checks++; if (rows !== er) $display("FAIL rand_rows[%0d]: got %h want %h", s, rows, er); else n_pass++;
      n_checks++; if (col_error !== ee) $display("FAIL rand_col_error[%0d]: got %b want %b", s, col_error, ee); else n_pass++;
      n_checks++; if (swap_pending !== m_pending) $display("FAIL rand_pending[%0d]: got %b want %b", s, swap_pending, m_pending); else n_pass++;
      n_checks++; if (bus.wr_ready !== !m_pending) $display("FAIL rand_ready[%0d]: got %b want %b", s, bus.wr_ready, !m_pending); else n_pass++;
    end
    idle_wr();
  endtask

`ifdef MATRIX_ROW_DRIVER_BLINK_EN
  task automatic test_blink();
    logic [ROWS-1:0] er;
    bit ee, sw;
    scan_pos = COLS - 1;
    for (int i = 0; i < U; i++) begin
      next_col(); set_wr(i, 7'h49 + 7'(i), i == U - 1); step(er, ee, sw);
    end
    idle_wr();
    for (int b = 1; b >= 0; b--) begin
      blink = b[0];
      repeat (6 * COLS) begin
        next_col(); step(er, ee, sw);
        n_checks++; if (rows !== er) $display("FAIL blink%0d_rows: got %h want %h", b, rows, er); else n_pass++;
      end
    end
    blink = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_back_to_back_stall();
    test_col_error();
    test_selector_held();
    test_reset_mid_load();
    test_random();
`ifdef MATRIX_ROW_DRIVER_BLINK_EN
    test_blink();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
